// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and its on-chip slave model.
package spi_pkg;

  localparam int unsigned DATA_W = 8;
  // Wide enough to hold DATA_W itself, not just DATA_W-1.
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StSclkHi,
    StSclkLo,
    StDone
  } spi_state_e;

endpackage

// File: rtl/spi_shift8.sv
// 8-bit parallel-load shift register.
// Bit 0 is the MSB and the serial output; data shifts toward bit 0 and
// the serial input enters at the last bit.
module spi_shift8
  import spi_pkg::*;
(
  input  logic              global_clk,
  input  logic              reset,
  input  logic              load,
  input  logic [0:DATA_W-1] load_val,
  input  logic              shift,
  input  logic              sin,
  output logic [0:DATA_W-1] q
);

  logic [0:DATA_W-1] q_q, q_d;

  // Load has priority over shift.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {q_q[1:DATA_W-1], sin};
    end
  end

  // Register update with asynchronous clear.
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/spi_main.sv
// SPI mode-0 master with an optional on-chip slave model.
// A rising edge on get_data starts one 8-bit full-duplex exchange.
module spi_main
  import spi_pkg::*;
#(
  parameter int unsigned INTERNAL_SLAVE = 1
) (
  input  logic              global_clk,
  input  logic              reset,
  input  logic              get_data,
  input  logic [0:DATA_W-1] m_reg,
  input  logic [0:DATA_W-1] s_reg,
  input  logic              miso,
  output logic              mosi,
  output logic              ss,
  output logic              sclk,
  output logic [0:DATA_W-1] m_out,
  output logic [0:DATA_W-1] s_out,
  output logic              done
);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [0:DATA_W-1] m_out_q, m_out_d;
  logic [0:DATA_W-1] s_out_q, s_out_d;
  logic              get_q;
  logic              get_rise;

  logic              load;
  logic              shift;
  logic [0:DATA_W-1] m_shift;
  logic [0:DATA_W-1] s_shift;
  logic              m_rx_bit;
  logic              s_rx_bit;

  assign get_rise = get_data & ~get_q;

  // The master hears the slave model's outgoing bit, or the pin when external.
  assign m_rx_bit = (INTERNAL_SLAVE != 0) ? s_shift[0] : miso;
  assign s_rx_bit = m_shift[0];

  spi_shift8 u_master_shift (
    .global_clk (global_clk),
    .reset      (reset),
    .load       (load),
    .load_val   (m_reg),
    .shift      (shift),
    .sin        (m_rx_bit),
    .q          (m_shift)
  );

  spi_shift8 u_slave_shift (
    .global_clk (global_clk),
    .reset      (reset),
    .load       (load),
    .load_val   (s_reg),
    .shift      (shift),
    .sin        (s_rx_bit),
    .q          (s_shift)
  );

  // Next-state logic: sampling happens at the end of the sclk-high phase, so
  // the shift lands on the same edge that drops sclk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_out_d = m_out_q;
    s_out_d = s_out_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (get_rise) begin
          state_d = StLead;
          load    = 1'b1;
          cnt_d   = '0;
        end
      end
      StLead: begin
        state_d = StSclkHi;
      end
      StSclkHi: begin
        shift   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = StSclkLo;
      end
      StSclkLo: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d = StDone;
          m_out_d = m_shift;
          s_out_d = s_shift;
        end else begin
          state_d = StSclkHi;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counter, edge-detect and result registers.
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      m_out_q <= '0;
      s_out_q <= '0;
      get_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_out_q <= m_out_d;
      s_out_q <= s_out_d;
      get_q   <= get_data;
    end
  end

  // Pin outputs decoded from state so an async reset drops them at once.
  always_comb begin
    ss   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StLead: begin
        ss   = 1'b0;
        mosi = m_shift[0];
      end
      StSclkHi: begin
        ss   = 1'b0;
        sclk = 1'b1;
        mosi = m_shift[0];
      end
      StSclkLo: begin
        ss   = 1'b0;
        mosi = m_shift[0];
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign m_out = m_out_q;
  assign s_out = s_out_q;

endmodule

// File: tb/tb_spi_main.sv
// Scoreboard bench: one instance with the internal slave model, one
// listening on miso. Each transfer pushes the expected exchange result;
// a monitor checks every done pulse against the queue head.
module tb_spi_main;

  typedef struct {
    logic [7:0] m_out;
    logic [7:0] s_out;
    logic [7:0] mosi;
  } exp_t;

  logic       global_clk = 1'b0;
  logic       reset      = 1'b0;
  logic       get_data   = 1'b0;
  logic [0:7] m_reg      = '0;
  logic [0:7] s_reg      = '0;
  logic       miso       = 1'b0;
  logic [7:0] miso_byte  = '0;

  logic       ss_w   [2];
  logic       sclk_w [2];
  logic       mosi_w [2];
  logic       done_w [2];
  logic [0:7] m_out_w[2];
  logic [0:7] s_out_w[2];

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  int         ss_cnt   [2];
  int         sclk_cnt [2];
  int         done_cnt [2];
  logic [7:0] mosi_cap [2];
  logic       prev_sclk[2];
  logic       prev_done[2];
  int         miso_idx;
  logic       prev_sclk_ext;

  spi_main #(.INTERNAL_SLAVE(1)) u_dut_int (
    .global_clk (global_clk),
    .reset      (reset),
    .get_data   (get_data),
    .m_reg      (m_reg),
    .s_reg      (s_reg),
    .miso       (miso),
    .mosi       (mosi_w[0]),
    .ss         (ss_w[0]),
    .sclk       (sclk_w[0]),
    .m_out      (m_out_w[0]),
    .s_out      (s_out_w[0]),
    .done       (done_w[0])
  );

  spi_main #(.INTERNAL_SLAVE(0)) u_dut_ext (
    .global_clk (global_clk),
    .reset      (reset),
    .get_data   (get_data),
    .m_reg      (m_reg),
    .s_reg      (s_reg),
    .miso       (miso),
    .mosi       (mosi_w[1]),
    .ss         (ss_w[1]),
    .sclk       (sclk_w[1]),
    .m_out      (m_out_w[1]),
    .s_out      (s_out_w[1]),
    .done       (done_w[1])
  );

  always #5 global_clk = ~global_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // External slave: present MSB first, advance after each sclk falling edge.
  always @(negedge global_clk) begin
    if (ss_w[1]) begin
      miso_idx = 0;
    end else if (prev_sclk_ext && !sclk_w[1]) begin
      miso_idx = miso_idx + 1;
    end
    miso = (miso_idx < 8) ? miso_byte[7 - miso_idx] : 1'b0;
    prev_sclk_ext = sclk_w[1];
  end

  // Monitor: collect mosi on sclk rise, count ss-low cycles, score done pulses.
  always @(negedge global_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        ss_cnt[i]    = 0;
        sclk_cnt[i]  = 0;
        mosi_cap[i]  = '0;
        prev_sclk[i] = 1'b0;
        prev_done[i] = 1'b0;
      end else begin
        if (sclk_w[i] && !prev_sclk[i]) begin
          mosi_cap[i] = {mosi_cap[i][6:0], mosi_w[i]};
          sclk_cnt[i]++;
        end
        if (!ss_w[i]) ss_cnt[i]++;
        if (done_w[i]) begin
          exp_t e;
          logic empty;
          done_cnt[i]++;
          check($sformatf("done_one_cycle[%0d]", i), 32'(prev_done[i]), 32'd0);
          empty = (i == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
          if (empty) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done[%0d]: got done with no pending transfer", i);
          end else begin
            if (i == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            check($sformatf("m_out[%0d]", i), 32'(m_out_w[i]), 32'(e.m_out));
            check($sformatf("s_out[%0d]", i), 32'(s_out_w[i]), 32'(e.s_out));
            check($sformatf("mosi_seq[%0d]", i), 32'(mosi_cap[i]), 32'(e.mosi));
            check($sformatf("ss_low_cycles[%0d]", i), 32'(ss_cnt[i]), 32'd17);
            check($sformatf("sclk_pulses[%0d]", i), 32'(sclk_cnt[i]), 32'd8);
            check($sformatf("ss_high_at_done[%0d]", i), 32'(ss_w[i]), 32'd1);
          end
          ss_cnt[i]   = 0;
          sclk_cnt[i] = 0;
          mosi_cap[i] = '0;
        end
        prev_sclk[i] = sclk_w[i];
        prev_done[i] = done_w[i];
      end
    end
  end

  // Wait for one done on the internal instance, bounded, then let things settle.
  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt[0] == d0 && n < 40) begin
      @(negedge global_clk);
      n++;
    end
    repeat (25) @(negedge global_clk);
  endtask

  // Reference: the two shift registers swap contents; mosi carries m MSB first.
  task automatic run_xfer(input logic [7:0] m, input logic [7:0] s, input logic [7:0] mi,
                          input bit disturb);
    int d0, d1;
    @(negedge global_clk);
    m_reg     = m;
    s_reg     = s;
    miso_byte = mi;
    sb0.push_back('{m_out: s,  s_out: m, mosi: m});
    sb1.push_back('{m_out: mi, s_out: m, mosi: m});
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    get_data = 1'b1;
    @(negedge global_clk);
    get_data = 1'b0;
    if (disturb) begin
      repeat (4) @(negedge global_clk);
      m_reg    = 8'($urandom);
      s_reg    = 8'($urandom);
      get_data = 1'b1;
      @(negedge global_clk);
      get_data = 1'b0;
    end
    wait_done(d0);
    check("done_count_int", 32'(done_cnt[0] - d0), 32'd1);
    check("done_count_ext", 32'(done_cnt[1] - d1), 32'd1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, d1, n;
    for (int i = 0; i < 2; i++) done_cnt[i] = 0;
    miso_idx      = 0;
    prev_sclk_ext = 1'b0;

    repeat (3) @(negedge global_clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ss[%0d]", i),    32'(ss_w[i]),    32'd1);
      check($sformatf("rst_sclk[%0d]", i),  32'(sclk_w[i]),  32'd0);
      check($sformatf("rst_mosi[%0d]", i),  32'(mosi_w[i]),  32'd0);
      check($sformatf("rst_done[%0d]", i),  32'(done_w[i]),  32'd0);
      check($sformatf("rst_m_out[%0d]", i), 32'(m_out_w[i]), 32'd0);
      check($sformatf("rst_s_out[%0d]", i), 32'(s_out_w[i]), 32'd0);
    end
    reset = 1'b1;
    repeat (3) @(negedge global_clk);

    // Directed cases.
    run_xfer(8'hFF, 8'hAA, 8'h96, 1'b0);
    run_xfer(8'hA5, 8'h3C, 8'h96, 1'b0);
    run_xfer(8'h5A, 8'hC3, 8'h69, 1'b1);

    // Randomised exchanges, some with mid-transfer disturbance.
    for (int k = 0; k < 16; k++) begin
      run_xfer(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Level held high: exactly one transfer.
    @(negedge global_clk);
    m_reg     = 8'h81;
    s_reg     = 8'h7E;
    miso_byte = 8'h42;
    sb0.push_back('{m_out: 8'h7E, s_out: 8'h81, mosi: 8'h81});
    sb1.push_back('{m_out: 8'h42, s_out: 8'h81, mosi: 8'h81});
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    get_data = 1'b1;
    repeat (50) @(negedge global_clk);
    get_data = 1'b0;
    repeat (25) @(negedge global_clk);
    check("held_high_done_int", 32'(done_cnt[0] - d0), 32'd1);
    check("held_high_done_ext", 32'(done_cnt[1] - d1), 32'd1);

    // Fresh reset clears results.
    reset = 1'b0;
    repeat (2) @(negedge global_clk);
    reset = 1'b1;
    @(negedge global_clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rerst_m_out[%0d]", i), 32'(m_out_w[i]), 32'd0);
      check($sformatf("rerst_s_out[%0d]", i), 32'(s_out_w[i]), 32'd0);
    end

    // Abort during the bit-4 exchange.
    m_reg     = 8'hE7;
    s_reg     = 8'h18;
    miso_byte = 8'hBD;
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    get_data = 1'b1;
    @(negedge global_clk);
    get_data = 1'b0;
    n = 0;
    while (sclk_cnt[0] < 4 && n < 40) begin
      @(negedge global_clk);
      n++;
    end
    check("abort_reached_bit4", 32'(sclk_cnt[0]), 32'd4);
    #3;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_ss[%0d]", i),   32'(ss_w[i]),   32'd1);
      check($sformatf("abort_sclk[%0d]", i), 32'(sclk_w[i]), 32'd0);
    end
    repeat (3) @(negedge global_clk);
    reset = 1'b1;
    repeat (30) @(negedge global_clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_m_out[%0d]", i), 32'(m_out_w[i]), 32'd0);
      check($sformatf("abort_s_out[%0d]", i), 32'(s_out_w[i]), 32'd0);
    end
    check("abort_no_done_int", 32'(done_cnt[0] - d0), 32'd0);
    check("abort_no_done_ext", 32'(done_cnt[1] - d1), 32'd0);
    check("sb_drained_int", 32'(sb0.size()), 32'd0);
    check("sb_drained_ext", 32'(sb1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
